cp0_regfile_mt: RTL and testbench
=================================

Name: cp0_regfile_mt

Overview:
Parametrised CP0 register file for the MIPS32 core. It provides COUNT with a prescaler, NUM_TIMERS independent COMPARE channels, and STATUS, CAUSE, EPC, PrId and Config. It also performs exception-entry and ERET state updates and produces a masked interrupt request. It sits beside the MEM/WB stage: writes arrive from mtc0 in WB, reads go to the EX-stage mfc0 path, and exception and ERET strobes come from the MEM-stage exception unit.

Parameters:
NUM_TIMERS, 2, number of COMPARE channels (1..4), selected by sel field.
COUNT_DIV, 1, COUNT increments once every COUNT_DIV clocks (1..16).
PRID_VAL, 32'h004C0102, read-only PrId value.
CONFIG_VAL, 32'h00008000, read-only Config value.

Ports:
clk  in  1  clock
rst  in  1  reset
we_i  in  1  mtc0 write enable
waddr_i  in  5  write register number
wsel_i  in  3  write select (COMPARE channel)
raddr_i  in  5  read register number
rsel_i  in  3  read select
data_i  in  32  write data
int_i  in  6  external hardware interrupts, level
excp_i  in  1  exception-entry strobe, one cycle
excp_code_i  in  5  ExcCode
excp_pc_i  in  32  PC of faulting instruction
excp_bd_i  in  1  faulting instruction is in a delay slot
eret_i  in  1  ERET strobe, one cycle
data_o  out  32  read data, combinational
count_o  out  32  COUNT
compare_o  out  32*NUM_TIMERS  COMPARE channels; channel k at bits [32k+31:32k]
status_o  out  32  STATUS
cause_o  out  32  CAUSE
epc_o  out  32  EPC
timer_int_o  out  NUM_TIMERS  per-channel sticky timer interrupt
int_req_o  out  1  masked interrupt request, combinational

Behaviour:
- Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Register numbers: COUNT 9, COMPARE 11, STATUS 12, CAUSE 13, EPC 14, PrId 15, Config 16.
- Reset values: COUNT 0, prescaler 0, all COMPARE 0, STATUS 32'h10000000, CAUSE 0, EPC 0, timer_int_o 0. data_o is 0 while rst is high.
- Prescaler: counts 0..COUNT_DIV-1. COUNT increments by 1 when the prescaler equals COUNT_DIV-1, and the prescaler then wraps to 0. COUNT wraps from FFFFFFFF to 0.
- mtc0 write to COUNT loads data_i, clears the prescaler, and wins over a same-cycle increment.
- Timer k match: if COMPARE[k] != 0 and COUNT == COMPARE[k] in cycle t, timer_int_o[k] = 1 from t+1. The bit is sticky.
- mtc0 write to COMPARE with wsel_i = k loads data_i and clears timer_int_o[k]. A write wins over a same-cycle match.
- Writes with wsel_i >= NUM_TIMERS are ignored. Reads with rsel_i >= NUM_TIMERS return 0.
- CAUSE is updated every cycle:
  - IP[6:2] (bits 14:10) <= int_i[4:0].
  - IP7 (bit 15) <= int_i[5] | (|timer_int_o).
  - TI (bit 30) <= |timer_int_o.
- CAUSE bits writable by mtc0: IP[1:0] (bits 9:8), WP (bit 22), IV (bit 23). All other CAUSE bits ignore mtc0.
- STATUS and EPC are fully writable by mtc0. PrId and Config ignore writes.
- int_req_o = STATUS.IE[0] & ~STATUS.EXL[1] & |(STATUS[15:8] & CAUSE[15:8]).
- Exception entry (excp_i = 1):
  - If EXL = 0: EPC <= excp_bd_i ? excp_pc_i - 4 : excp_pc_i, and CAUSE.BD[31] <= excp_bd_i.
  - If EXL = 1: EPC and BD are unchanged.
  - In both cases: CAUSE.ExcCode[6:2] <= excp_code_i and EXL <= 1.
- ERET (eret_i = 1): EXL <= 0.
- Priority: excp_i over eret_i. In any cycle with excp_i or eret_i high, mtc0 writes to STATUS, CAUSE and EPC are dropped. COUNT and COMPARE writes still take effect.
- Read path: data_o is a combinational mux of the registered values. There is no write-to-read bypass; forwarding is done by the pipeline. Unmapped registers read 0.
- Reset asserted mid-operation restores all reset values on the next edge. Pending timer bits and the prescaler phase are lost.

Test Plan:
- Reset then COUNT_DIV=2: 10 clocks -> COUNT=5. mtc0 COUNT=FFFFFFFF, then 2 clocks -> COUNT=0.
- NUM_TIMERS=2: COMPARE0=20, COMPARE1=30, COUNT=0, COUNT_DIV=1 -> timer_int_o=01 in the cycle after COUNT=20 and 11 after COUNT=30. Write COMPARE1 -> timer_int_o=01. CAUSE[30]=1 and CAUSE[15]=1 while either bit is set.
- Write COMPARE0 in the same cycle COUNT==COMPARE0 -> timer_int_o[0] stays 0. Write with wsel=3 -> no state change; read with rsel=3 returns 0.
- STATUS=0000FF01, int_i=000100 -> CAUSE[12]=1 and int_req_o=1. excp_i with code 00000, pc=80000100, bd=1 -> EPC=800000FC, CAUSE[31]=1, EXL=1, int_req_o=0.
- Second excp_i while EXL=1 with pc=80000200 -> EPC remains 800000FC, ExcCode updated. eret_i -> EXL=0.
- Same cycle excp_i, eret_i and mtc0 STATUS=0 -> EXL=1 and the STATUS write is dropped. mtc0 CAUSE=FFFFFFFF -> only bits 23, 22, 9 and 8 change.

Source files
------------

// File: rtl/cp0_regfile_mt.sv
// CP0 register file: COUNT with prescaler, per-channel COMPARE timers,
// STATUS/CAUSE/EPC, exception/ERET updates and the masked interrupt request.
module cp0_regfile_mt #(
    parameter int          NUM_TIMERS = 2,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [4:0]               waddr_i,
    input  logic [2:0]               wsel_i,
    input  logic [4:0]               raddr_i,
    input  logic [2:0]               rsel_i,
    input  logic [31:0]              data_i,
    input  logic [5:0]               int_i,
    input  logic                     excp_i,
    input  logic [4:0]               excp_code_i,
    input  logic [31:0]              excp_pc_i,
    input  logic                     excp_bd_i,
    input  logic                     eret_i,
    output logic [31:0]              data_o,
    output logic [31:0]              count_o,
    output logic [32*NUM_TIMERS-1:0] compare_o,
    output logic [31:0]              status_o,
    output logic [31:0]              cause_o,
    output logic [31:0]              epc_o,
    output logic [NUM_TIMERS-1:0]    timer_int_o,
    output logic                     int_req_o
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    localparam logic [31:0] STATUS_RST = 32'h10000000;
    localparam logic [3:0]  PS_LAST    = 4'(COUNT_DIV - 1);

    logic [31:0] count_q;
    logic [3:0]  ps_q;
    logic [31:0] compare_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] tint_q;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;

    logic        tany;
    logic        exl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_priv;
    logic [31:0] epc_new;
    logic [31:0] rd_cmp;

    assign tany     = |tint_q;
    assign exl      = status_q[1];
    assign wr_count = we_i && (waddr_i == REG_COUNT);
    assign wr_cmp   = we_i && (waddr_i == REG_COMPARE);
    // Privileged-state writes lose to same-cycle exception/ERET updates.
    assign wr_priv  = we_i && !excp_i && !eret_i;
    assign epc_new  = excp_bd_i ? excp_pc_i - 32'd4 : excp_pc_i;

    // COUNT advances once per COUNT_DIV clocks; mtc0 reloads and rephases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ps_q    <= '0;
        end else if (wr_count) begin
            count_q <= data_i;
            ps_q    <= '0;
        end else if (ps_q == PS_LAST) begin
            count_q <= count_q + 32'd1;
            ps_q    <= '0;
        end else begin
            ps_q <= ps_q + 4'd1;
        end
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
        logic hit;
        logic wr;

        assign hit = (compare_q[k] != '0) && (count_q == compare_q[k]);
        assign wr  = wr_cmp && (wsel_i == 3'(k));

        // Channel k: COMPARE write clears the sticky bit and beats a match.
        always_ff @(posedge clk) begin
            if (rst) begin
                compare_q[k] <= '0;
                tint_q[k]    <= 1'b0;
            end else if (wr) begin
                compare_q[k] <= data_i;
                tint_q[k]    <= 1'b0;
            end else if (hit) begin
                tint_q[k] <= 1'b1;
            end
        end

        assign compare_o[32*k +: 32] = compare_q[k];
    end

    // STATUS: exception sets EXL, ERET clears it, otherwise mtc0 writes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
        end else if (excp_i) begin
            status_q[1] <= 1'b1;
        end else if (eret_i) begin
            status_q[1] <= 1'b0;
        end else if (wr_priv && waddr_i == REG_STATUS) begin
            status_q <= data_i;
        end
    end

    // CAUSE: IP/TI sampled every cycle; ExcCode/BD on exception; few bits via mtc0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
        end else begin
            cause_q[14:10] <= int_i[4:0];
            cause_q[15]    <= int_i[5] | tany;
            cause_q[30]    <= tany;
            if (excp_i) begin
                cause_q[6:2] <= excp_code_i;
                if (!exl) begin
                    cause_q[31] <= excp_bd_i;
                end
            end else if (wr_priv && waddr_i == REG_CAUSE) begin
                cause_q[9:8]   <= data_i[9:8];
                cause_q[23:22] <= data_i[23:22];
            end
        end
    end

    // EPC: captured only on a first-level exception, else mtc0 writable.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (excp_i) begin
            if (!exl) begin
                epc_q <= epc_new;
            end
        end else if (wr_priv && waddr_i == REG_EPC) begin
            epc_q <= data_i;
        end
    end

    // COMPARE read select; out-of-range selects read zero.
    always_comb begin
        rd_cmp = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (rsel_i == 3'(k)) begin
                rd_cmp = compare_q[k];
            end
        end
    end

    // mfc0 read mux over registered state, forced to zero during reset.
    always_comb begin
        data_o = '0;
        if (!rst) begin
            unique case (raddr_i)
                REG_COUNT:   data_o = count_q;
                REG_COMPARE: data_o = rd_cmp;
                REG_STATUS:  data_o = status_q;
                REG_CAUSE:   data_o = cause_q;
                REG_EPC:     data_o = epc_q;
                REG_PRID:    data_o = PRID_VAL;
                REG_CONFIG:  data_o = CONFIG_VAL;
                default:     data_o = '0;
            endcase
        end
    end

    assign int_req_o   = status_q[0] & ~status_q[1] &
                         (|(status_q[15:8] & cause_q[15:8]));
    assign count_o     = count_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = tint_q;

endmodule

// File: tb/tb_cp0_regfile_mt.sv
// Randomised bench for cp0_regfile_mt against a per-cycle behavioural model
// built from the register rules; directed cases cover timer and exception corners.
module tb_cp0_regfile_mt;

    localparam int NT  = 2;
    localparam int DIV = 2;
    localparam logic [31:0] PRID = 32'h004C0102;
    localparam logic [31:0] CFG  = 32'h00008000;
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [4:0]    waddr;
    logic [2:0]    wsel;
    logic [4:0]    raddr;
    logic [2:0]    rsel;
    logic [31:0]   wdata;
    logic [5:0]    irq;
    logic          excp;
    logic [4:0]    ecode;
    logic [31:0]   epc_in;
    logic          bd;
    logic          eret;
    logic [31:0]   rdata;
    logic [31:0]   count;
    logic [32*NT-1:0] compare;
    logic [31:0]   status;
    logic [31:0]   cause;
    logic [31:0]   epc;
    logic [NT-1:0] tint;
    logic          ireq;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model state
    logic [31:0] m_count;
    int          m_ps;
    logic [31:0] m_cmp [NT];
    logic        m_tint [NT];
    logic [31:0] m_status;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    cp0_regfile_mt #(
        .NUM_TIMERS(NT),
        .COUNT_DIV (DIV),
        .PRID_VAL  (PRID),
        .CONFIG_VAL(CFG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we),
        .waddr_i    (waddr),
        .wsel_i     (wsel),
        .raddr_i    (raddr),
        .rsel_i     (rsel),
        .data_i     (wdata),
        .int_i      (irq),
        .excp_i     (excp),
        .excp_code_i(ecode),
        .excp_pc_i  (epc_in),
        .excp_bd_i  (bd),
        .eret_i     (eret),
        .data_o     (rdata),
        .count_o    (count),
        .compare_o  (compare),
        .status_o   (status),
        .cause_o    (cause),
        .epc_o      (epc),
        .timer_int_o(tint),
        .int_req_o  (ireq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_tany();
        logic a = 1'b0;
        for (int k = 0; k < NT; k++) a |= m_tint[k];
        return a;
    endfunction

    function automatic logic [31:0] m_read();
        if (rst) return 32'h0;
        case (raddr)
            5'd9:  return m_count;
            5'd11: return (int'(rsel) < NT) ? m_cmp[rsel] : 32'h0;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            5'd16: return CFG;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_ireq();
        return m_status[0] && !m_status[1] && ((m_status[15:8] & m_cause[15:8]) != 0);
    endfunction

    // one clock of the architectural rules, evaluated on pre-edge state
    task automatic model_step();
        logic        tany;
        logic        exl;
        logic        priv;
        logic [31:0] nc;
        if (rst) begin
            m_count = 0; m_ps = 0; m_status = 32'h10000000;
            m_cause = 0; m_epc = 0;
            for (int k = 0; k < NT; k++) begin m_cmp[k] = 0; m_tint[k] = 0; end
            return;
        end
        tany = m_tany();
        exl  = m_status[1];
        priv = we && !excp && !eret;
        for (int k = 0; k < NT; k++) begin
            if (we && waddr == 11 && int'(wsel) == k) begin
                m_cmp[k] = wdata; m_tint[k] = 0;
            end else if (m_cmp[k] != 0 && m_count == m_cmp[k]) begin
                m_tint[k] = 1;
            end
        end
        if (we && waddr == 9) begin
            m_count = wdata; m_ps = 0;
        end else if (m_ps == DIV - 1) begin
            m_count = m_count + 1; m_ps = 0;
        end else begin
            m_ps = m_ps + 1;
        end
        nc = m_cause;
        nc[14:10] = irq[4:0];
        nc[15] = irq[5] | tany;
        nc[30] = tany;
        if (excp) begin
            nc[6:2] = ecode;
            if (!exl) begin
                nc[31] = bd;
                m_epc = bd ? epc_in - 4 : epc_in;
            end
            m_status[1] = 1'b1;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (priv) begin
            if (waddr == 13) nc = (nc & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
            if (waddr == 12) m_status = wdata;
            if (waddr == 14) m_epc = wdata;
        end
        m_cause = nc;
    endtask

    // check combinational outputs, clock once, then check registered state
    task automatic tick();
        #1;
        check("data_o", rdata, m_read());
        check("int_req", 32'(ireq), 32'(m_ireq()));
        @(posedge clk);
        model_step();
        #1;
        check("count", count, m_count);
        check("status", status, m_status);
        check("cause", cause, m_cause);
        check("epc", epc, m_epc);
        for (int k = 0; k < NT; k++) begin
            check($sformatf("cmp%0d", k), compare[32*k +: 32], m_cmp[k]);
            check($sformatf("tint%0d", k), 32'(tint[k]), 32'(m_tint[k]));
        end
        we = 0; excp = 0; eret = 0; rst = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] d);
        we = 1; waddr = a; wsel = s; wdata = d;
    endtask

    initial begin
        int c;
        int budget;
        logic [31:0] target;
        int regs [8] = '{9, 11, 12, 13, 14, 15, 16, 3};

        rst = 1; we = 0; waddr = 0; wsel = 0; raddr = 9; rsel = 0;
        wdata = 0; irq = 0; excp = 0; ecode = 0; epc_in = 0; bd = 0; eret = 0;
        m_count = 'x; m_ps = 0; m_status = 'x; m_cause = 'x; m_epc = 'x;
        for (int k = 0; k < NT; k++) begin m_cmp[k] = 'x; m_tint[k] = 0; end

        // reset: data_o is zero while rst is high
        @(posedge clk); #1;
        rst = 1; raddr = 15;
        #1 check("rst_data", rdata, 32'h0);
        tick();
        check("rst_status", status, 32'h10000000);

        // prescaler: 10 clocks at DIV=2 -> COUNT=5
        raddr = 9;
        for (int i = 0; i < 10; i++) tick();
        check("count10", count, 32'd5);
        mtc0(9, 0, 32'hFFFFFFFF);
        tick();
        tick(); tick();
        check("count_wrap", count, 32'h0);

        // timer matches
        mtc0(11, 0, 32'd20); tick();
        mtc0(11, 1, 32'd30); tick();
        mtc0(9, 0, 32'd0); tick();
        budget = 200;
        while (tint[0] == 0 && budget > 0) begin tick(); budget--; end
        check("t0_bound", 32'(budget > 0), 32'd1);
        check("t0_only", 32'(tint), 32'h1);
        budget = 200;
        while (tint[1] == 0 && budget > 0) begin tick(); budget--; end
        check("t1_bound", 32'(budget > 0), 32'd1);
        check("t_both", 32'(tint), 32'h3);
        tick();
        check("cause_ti", 32'(cause[30]), 32'd1);
        check("cause_ip7", 32'(cause[15]), 32'd1);
        mtc0(11, 1, 32'd1000); tick();
        check("t1_clr", 32'(tint), 32'h1);

        // COMPARE write on the matching cycle beats the match
        target = count + 6;
        mtc0(11, 0, target); tick();
        budget = 100;
        while (count != target && budget > 0) begin tick(); budget--; end
        check("match_bound", 32'(budget > 0), 32'd1);
        mtc0(11, 0, 32'hFFFF0000); tick();
        check("wr_beats_match", 32'(tint[0]), 32'd0);

        // out-of-range select
        mtc0(11, 3, 32'd5); tick();
        raddr = 11; rsel = 3;
        #1 check("rsel3", rdata, 32'h0);
        rsel = 0;

        // interrupt request and exception entry
        mtc0(12, 0, 32'h0000FF01); irq = 6'b000100; tick();
        tick();
        check("ip4", 32'(cause[12]), 32'd1);
        check("ireq_on", 32'(ireq), 32'd1);
        excp = 1; ecode = 0; epc_in = 32'h80000100; bd = 1; tick();
        check("epc_bd", epc, 32'h800000FC);
        check("bd_bit", 32'(cause[31]), 32'd1);
        check("exl_set", 32'(status[1]), 32'd1);
        check("ireq_off", 32'(ireq), 32'd0);
        excp = 1; ecode = 5'd7; epc_in = 32'h80000200; bd = 0; tick();
        check("epc_hold", epc, 32'h800000FC);
        check("code_upd", 32'(cause[6:2]), 32'd7);
        eret = 1; tick();
        check("eret_exl", 32'(status[1]), 32'd0);
        excp = 1; eret = 1; mtc0(12, 0, 32'h0); tick();
        check("prio_exl", 32'(status[1]), 32'd1);
        check("drop_stat", 32'(status[0]), 32'd1);
        target = cause;
        mtc0(13, 0, 32'hFFFFFFFF); tick();
        check("cause_wr", cause & CAUSE_WMASK, CAUSE_WMASK);
        check("cause_ro", cause & 32'h3F00007C, target & 32'h3F00007C);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            raddr = 5'(regs[$urandom_range(0, 7)]);
            rsel  = 3'($urandom_range(0, 3));
            irq   = 6'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                c = regs[$urandom_range(0, 7)];
                we = 1; waddr = 5'(c); wsel = 3'($urandom_range(0, 3));
                wdata = $urandom;
                if (c == 11) wdata = m_count + $urandom_range(0, 12);
                if (c == 9 && $urandom_range(0, 1) == 0)
                    wdata = 32'hFFFFFFF0 + $urandom_range(0, 15);
            end
            excp   = ($urandom_range(0, 15) == 0);
            eret   = ($urandom_range(0, 15) == 0);
            ecode  = 5'($urandom);
            epc_in = $urandom;
            bd     = 1'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
